inst_queue: RTL and testbench

- Parametrised instruction buffer between instruction fetch and decode. It replaces the fixed single-entry if_id register with a DEPTH-entry FIFO of {pc, inst} pairs.
- Valid/ready handshakes on both sides. Synchronous flush for branch redirect. almost_full output for fetch throttling.
- Lets fetch run ahead of decode stalls without losing instructions.

---
 rtl/inst_queue.sv | 92 +++++++++
 tb/tb_inst_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {pc, inst}
// pairs with valid/ready handshakes on both sides, synchronous flush and almost_full.
module inst_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        if_valid,
  output logic                        if_ready,
  input  logic [ADDR_WIDTH-1:0]       if_pc,
  input  logic [INST_WIDTH-1:0]       if_inst,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [ADDR_WIDTH-1:0]       id_pc,
  output logic [INST_WIDTH-1:0]       id_inst,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        almost_full
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_AF   = (PTR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q,    cnt_d;

  logic push, pop, mem_we;

  // if_ready depends only on registered occupancy, never on id_ready
  assign if_ready    = rst & (cnt_q != CNT_FULL);
  assign id_valid    = (cnt_q != '0);
  assign id_pc       = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign id_inst     = id_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign count       = cnt_q;
  assign almost_full = (cnt_q >= CNT_AF);

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      mem_we = push;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=4, AF_MARGIN=1).
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;
  logic        almost_full;

  int n_assert = 0;
  int n_fail   = 0;

  inst_queue #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .DEPTH(4),
    .AF_MARGIN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    id_ready = 1'b0;
    #1 rst = 1'b0;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_id_valid", id_valid, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_count", count, 0);
    end
    rst = 1'b1;
    tick();
    chk("idle_if_ready", if_ready, 1);
    chk("idle_id_valid", id_valid, 0);
    chk("idle_id_pc", id_pc, 0);

    // fill to full
    if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_pc   = 32'h1c00_0000 + 32'(4 * i);
      if_inst = 32'hA0 + 32'(i);
      tick();
      chk("fill_count", count, 64'(i + 1));
      chk("fill_af", almost_full, (i + 1 >= 3) ? 1 : 0);
      chk("fill_if_ready", if_ready, (i + 1 < 4) ? 1 : 0);
      chk("fill_head_pc", id_pc, 32'h1c00_0000);
    end
    if_pc   = 32'h1c00_0010;
    if_inst = 32'hA4;
    tick();
    chk("full_count", count, 4);
    chk("full_head_pc", id_pc, 32'h1c00_0000);
    chk("full_head_inst", id_inst, 32'hA0);

    // drain with wrap, pushing as space frees
    id_ready = 1'b1;
    tick();
    chk("drain0_pc", id_pc, 32'h1c00_0004);
    chk("drain0_count", count, 3);
    tick();
    chk("drain1_pc", id_pc, 32'h1c00_0008);
    chk("drain1_count", count, 3);
    if_pc   = 32'h1c00_0014;
    if_inst = 32'hA5;
    tick();
    chk("drain2_pc", id_pc, 32'h1c00_000c);
    chk("drain2_count", count, 3);
    if_valid = 1'b0;
    tick();
    chk("drain3_pc", id_pc, 32'h1c00_0010);
    chk("drain3_inst", id_inst, 32'hA4);
    chk("drain3_count", count, 2);
    tick();
    chk("drain4_pc", id_pc, 32'h1c00_0014);
    chk("drain4_inst", id_inst, 32'hA5);
    chk("drain4_count", count, 1);
    tick();
    chk("drain5_valid", id_valid, 0);
    chk("drain5_pc", id_pc, 0);
    chk("drain5_count", count, 0);

    // simultaneous push/pop at count=2
    id_ready = 1'b0;
    if_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_pc   = 32'h1c00_0020 + 32'(4 * i);
      if_inst = 32'hB0 + 32'(i);
      tick();
    end
    chk("pp_pre_count", count, 2);
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if_pc   = 32'h1c00_0028 + 32'(4 * k);
      if_inst = 32'hB2 + 32'(k);
      tick();
      chk("pp_count", count, 2);
      chk("pp_head_pc", id_pc, 32'h1c00_0020 + 32'(4 * (k + 1)));
      chk("pp_head_inst", id_inst, 32'hB0 + 32'(k + 1));
    end

    // flush at count=3 with concurrent push and pop
    id_ready = 1'b0;
    if_pc    = 32'h1c00_003c;
    if_inst  = 32'hB7;
    tick();
    chk("pre_flush_count", count, 3);
    flush    = 1'b1;
    id_ready = 1'b1;
    if_pc    = 32'h1c00_0100;
    if_inst  = 32'hEE;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", id_valid, 0);
    chk("flush_pc", id_pc, 0);
    chk("flush_if_ready", if_ready, 1);
    tick();
    chk("flush_idle_valid", id_valid, 0);
    if_valid = 1'b1;
    if_pc    = 32'h1c00_0200;
    if_inst  = 32'hC0;
    tick();
    chk("post_flush_pc", id_pc, 32'h1c00_0200);
    chk("post_flush_inst", id_inst, 32'hC0);
    chk("post_flush_count", count, 1);

    // async reset mid-stream at count=2
    if_pc   = 32'h1c00_0204;
    if_inst = 32'hC1;
    tick();
    if_valid = 1'b0;
    chk("pre_arst_count", count, 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_if_ready", if_ready, 0);
    chk("arst_af", almost_full, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_arst_valid", id_valid, 0);
    chk("post_arst_count", count, 0);
    chk("post_arst_if_ready", if_ready, 1);
    if_valid = 1'b1;
    if_pc    = 32'h1c00_0300;
    if_inst  = 32'hD0;
    tick();
    if_valid = 1'b0;
    chk("post_arst_pc", id_pc, 32'h1c00_0300);
    chk("post_arst_inst", id_inst, 32'hD0);
    chk("post_arst_count1", count, 1);
    id_ready = 1'b1;
    tick();
    chk("final_valid", id_valid, 0);
    chk("final_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
